// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
//   Multi-channel tick / clock-enable generator. Each channel divides clk by a
//   runtime-programmable divisor and produces a single-cycle tick strobe plus
//   a 50% duty wave level that toggles on every tick. Everything stays in the
//   clk domain; consumers use tick as a clock enable.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   en         per-channel count enable (disabled cycles stretch the period)
//   sync_clr   synchronous clear of every channel phase
//   cfg_we     divisor write strobe for channel cfg_ch
//   cfg_ch     channel select for write and readback
//   cfg_div    divisor value to write (0 stalls the channel)
//   cfg_rdata  divisor of channel cfg_ch, combinational, 0 when out of range
//   tick       registered single-cycle strobe, once per div enabled cycles
//   wave       registered level, toggles on every tick
// ---------------------------------------------------------------------------
module tick_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27,
  parameter int CH_W   = 2,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {27'd25_000_000, 27'd200_000,
                                                27'd50_000_000, 27'd100_000_000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [CNT_W-1:0]  cfg_rdata,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave
);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wave_q, wave_d;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] wr_sel;

  // One-hot decode of cfg_ch; an out-of-range select matches no channel, so
  // writes to it are dropped and readback returns 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = (int'(cfg_ch) == i);
      wr_sel[i] = cfg_we && ch_sel[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      wave_d[i] = wave_q[i];

      if (sync_clr || wr_sel[i]) begin
        // A write restarts the phase; sync_clr alone restarts every phase,
        // and a write landing together with it still takes the new divisor.
        if (wr_sel[i]) begin
          div_d[i] = cfg_div;
        end
        cnt_d[i]  = '0;
        wave_d[i] = 1'b0;
      end else if (div_q[i] == '0) begin
        cnt_d[i]  = '0;
        wave_d[i] = 1'b0;
      end else if (!en[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
        // Every write zeroes cnt, so cnt never passes div-1 and equality is
        // a sufficient terminal-count test.
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        wave_d[i] = ~wave_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DEF_DIV[i*CNT_W +: CNT_W];
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
      wave_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick_q <= tick_d;
      wave_q <= wave_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) begin
        cfg_rdata = div_q[i];
      end
    end
  end

  assign tick = tick_q;
  assign wave = wave_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_tick_gen_multi
//   Directed bench for tick_gen_multi. A 4-channel instance (divisors 5/3/2/0)
//   is checked every cycle against a count-based model: per channel it keeps
//   the number of enabled edges since the last restart n, and derives
//   tick = (n % div == 0) and wave = (n / div) odd. Literal cycle-numbered
//   expectations pin that model. A 5-channel instance with a 3-bit select
//   covers out-of-range writes and readback.
// ---------------------------------------------------------------------------
module tb_tick_gen_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    en;
  logic          sync_clr;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [7:0]    cfg_div;
  logic [7:0]    cfg_rdata;
  logic [3:0]    tick;
  logic [3:0]    wave;

  logic [4:0]    en5;
  logic          sync_clr5;
  logic          cfg_we5;
  logic [2:0]    cfg_ch5;
  logic [7:0]    cfg_div5;
  logic [7:0]    cfg_rdata5;
  logic [4:0]    tick5;
  logic [4:0]    wave5;

  int checks = 0;
  int errors = 0;

  tick_gen_multi #(
    .NUM_CH (4),
    .CNT_W  (8),
    .CH_W   (2),
    .DEF_DIV({8'd0, 8'd2, 8'd3, 8'd5})
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_rdata(cfg_rdata),
    .tick     (tick),
    .wave     (wave)
  );

  tick_gen_multi #(
    .NUM_CH (5),
    .CNT_W  (8),
    .CH_W   (3),
    .DEF_DIV({8'd4, 8'd0, 8'd2, 8'd3, 8'd5})
  ) dut5 (
    .clk      (clk),
    .rst      (rst),
    .en       (en5),
    .sync_clr (sync_clr5),
    .cfg_we   (cfg_we5),
    .cfg_ch   (cfg_ch5),
    .cfg_div  (cfg_div5),
    .cfg_rdata(cfg_rdata5),
    .tick     (tick5),
    .wave     (wave5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (4-channel instance) ----------------
  logic [7:0] def4 [NCH] = '{8'd5, 8'd3, 8'd2, 8'd0};
  logic [7:0] mdiv [NCH];
  int         mn   [NCH];
  logic [3:0] mtick;
  logic [3:0] mwave;

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (!rst) begin
          mdiv[i]  = def4[i];
          mn[i]    = 0;
          mtick[i] = 1'b0;
          mwave[i] = 1'b0;
        end else if (sync_clr || (cfg_we && int'(cfg_ch) == i)) begin
          if (cfg_we && int'(cfg_ch) == i) mdiv[i] = cfg_div;
          mn[i]    = 0;
          mtick[i] = 1'b0;
          mwave[i] = 1'b0;
        end else if (mdiv[i] == 8'd0) begin
          mn[i]    = 0;
          mtick[i] = 1'b0;
          mwave[i] = 1'b0;
        end else if (en[i]) begin
          mn[i]    = mn[i] + 1;
          mtick[i] = ((mn[i] % int'(mdiv[i])) == 0);
          mwave[i] = (((mn[i] / int'(mdiv[i])) % 2) == 1);
        end else begin
          mtick[i] = 1'b0;
        end
      end
      #1;
      chk("model_tick", 32'(tick), 32'(mtick));
      chk("model_wave", 32'(wave), 32'(mwave));
      chk("model_rdata", 32'(cfg_rdata), 32'(mdiv[cfg_ch]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
    cyc(1);
    cfg_we  = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] ch, input logic [7:0] d);
    cfg_we5  = 1'b1;
    cfg_ch5  = ch;
    cfg_div5 = d;
    cyc(1);
    cfg_we5  = 1'b0;
  endtask

  // Cycles counted from the first rising edge after reset release.
  task automatic startup_checks(input string tag);
    cyc(5);
    chk({tag, "_tick_c5"}, 32'(tick), 32'(4'b0001));
    chk({tag, "_tick5_c5"}, 32'(tick5), 32'(5'b00001));
    cyc(1);
    chk({tag, "_tick_c6"}, 32'(tick), 32'(4'b0110));
    chk({tag, "_tick5_c6"}, 32'(tick5), 32'(5'b00110));
    cyc(4);
    chk({tag, "_tick_c10"}, 32'(tick), 32'(4'b0101));
    chk({tag, "_wave_c10"}, 32'(wave), 32'(4'b0110));
    chk({tag, "_tick5_c10"}, 32'(tick5), 32'(5'b00101));
    chk({tag, "_wave5_c10"}, 32'(wave5), 32'(5'b00110));
  endtask

  logic [7:0] def5 [8] = '{8'd5, 8'd3, 8'd2, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0};

  initial begin
    rst       = 1'b0;
    en        = 4'b0000;
    sync_clr  = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
    en5       = 5'b11111;
    sync_clr5 = 1'b0;
    cfg_we5   = 1'b0;
    cfg_ch5   = 3'd0;
    cfg_div5  = 8'd0;

    // Reset held, then release with all channels enabled.
    cyc(5);
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_rdata0", 32'(cfg_rdata), 32'(5));
    rst = 1'b1;
    en  = 4'b1111;
    startup_checks("s1");               // now at cycle 10
    cyc(5);                             // cycle 15
    chk("s1_tick_c15", 32'(tick), 32'(4'b0011));
    chk("s1_wave_c15", 32'(wave), 32'(4'b0111));

    // Rewrite ch0 two cycles into its period.
    cyc(2);                             // cycle 17
    wr(2'd0, 8'd7);                     // write edge 18
    cyc(6);                             // cycle 24
    chk("s2_tick0_c24", 32'(tick[0]), 32'(0));
    cyc(1);                             // cycle 25
    chk("s2_tick_c25", 32'(tick), 32'(4'b0001));
    chk("s2_rdata0", 32'(cfg_rdata), 32'(7));
    cyc(7);                             // cycle 32
    chk("s2_tick_c32", 32'(tick), 32'(4'b0101));

    // Gate ch1 for four cycles mid-period.
    cyc(2);                             // cycle 34
    en = 4'b1101;
    cyc(4);                             // cycle 38
    chk("s3_wave1_gap", 32'(wave[1]), 32'(1));
    en = 4'b1111;
    cyc(1);                             // cycle 39
    chk("s3_tick_c39", 32'(tick), 32'(4'b0001));
    cyc(1);                             // cycle 40
    chk("s3_tick_c40", 32'(tick), 32'(4'b0110));
    cyc(3);                             // cycle 43
    chk("s3_tick_c43", 32'(tick), 32'(4'b0010));

    // sync_clr on ch2's terminal edge, with a concurrent ch0 write back to 5.
    sync_clr = 1'b1;
    cfg_we   = 1'b1;
    cfg_ch   = 2'd0;
    cfg_div  = 8'd5;
    cyc(1);                             // cycle 44
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    chk("s4_tick_c44", 32'(tick), 32'(0));
    chk("s4_wave_c44", 32'(wave), 32'(0));
    chk("s4_rdata0", 32'(cfg_rdata), 32'(5));
    cyc(2);                             // cycle 46
    chk("s4_tick_c46", 32'(tick), 32'(4'b0100));
    cyc(3);                             // cycle 49
    chk("s4_tick_c49", 32'(tick), 32'(4'b0001));

    // ch3 at div=1, then stalled with div=0.
    wr(2'd3, 8'd1);                     // write edge 50
    cyc(1);                             // cycle 51
    chk("s5_tick3_c51", 32'(tick[3]), 32'(1));
    chk("s5_wave3_c51", 32'(wave[3]), 32'(1));
    cyc(1);                             // cycle 52
    chk("s5_tick3_c52", 32'(tick[3]), 32'(1));
    chk("s5_wave3_c52", 32'(wave[3]), 32'(0));
    wr(2'd3, 8'd0);                     // write edge 53
    chk("s5_tick3_c53", 32'(tick[3]), 32'(0));
    chk("s5_wave3_c53", 32'(wave[3]), 32'(0));
    cyc(1);
    chk("s5_tick3_c54", 32'(tick[3]), 32'(0));

    // Out-of-range select on the 5-channel instance.
    cfg_ch5 = 3'd7;
    #1;
    chk("s5_oor_rdata", 32'(cfg_rdata5), 32'(0));
    cyc(1);
    wr5(3'd7, 8'd9);
    for (int c = 0; c < 8; c++) begin
      cfg_ch5 = 3'(c);
      #1;
      chk($sformatf("s5_rd5_ch%0d", c), 32'(cfg_rdata5), 32'(def5[c]));
    end
    cyc(1);
    wr5(3'd4, 8'd9);
    cfg_ch5 = 3'd4;
    #1;
    chk("s5_rd5_ch4_new", 32'(cfg_rdata5), 32'(9));

    // Asynchronous reset between edges; divisors revert.
    cyc(1);
    wr(2'd1, 8'd9);
    cfg_ch = 2'd1;
    #1;
    chk("s6_rdata1_pre", 32'(cfg_rdata), 32'(9));
    #1;
    rst = 1'b0;
    #1;
    chk("s6_async_tick", 32'(tick), 32'(0));
    chk("s6_async_wave", 32'(wave), 32'(0));
    chk("s6_async_wave5", 32'(wave5), 32'(0));
    chk("s6_rdata1_rst", 32'(cfg_rdata), 32'(3));
    cfg_ch5 = 3'd4;
    #1;
    chk("s6_rd5_ch4_rst", 32'(cfg_rdata5), 32'(4));
    cyc(3);
    cfg_ch = 2'd0;
    rst    = 1'b1;
    en     = 4'b1111;
    startup_checks("s6");
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Parametrised multi-channel tick/clock-enable generator; next generation of the stopwatch `clock` divider.
- Replaces fixed `clk_1hz`/`clk_fast` outputs with NUM_CH independent channels.
- Each channel has a runtime-programmable divisor, a per-channel enable, a single-cycle `tick` strobe and a toggling `wave` output.
- Feeds the stopwatch counters (1 Hz / 2 Hz), display multiplexing and blink logic. All consumers stay on `clk`; no derived clocks.

Parameters:
- NUM_CH, 4, number of channels.
- CNT_W, 27, divisor and counter width. Maximum period is 2^CNT_W-1 cycles.
- CH_W, 2, channel select width; equals $clog2(NUM_CH).
- DEF_DIV, {27'd25_000_000, 27'd200_000, 27'd50_000_000, 27'd100_000_000}, packed NUM_CH*CNT_W reset divisors. Channel 0 is in the LSBs. At 100 MHz this gives 1 Hz, 2 Hz, 500 Hz, 4 Hz.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, NUM_CH, per-channel count enable.
- sync_clr, in, 1, synchronous clear of all channel phases.
- cfg_we, in, 1, divisor write strobe.
- cfg_ch, in, CH_W, channel select for write and readback.
- cfg_div, in, CNT_W, divisor value to write.
- cfg_rdata, out, CNT_W, divisor of channel cfg_ch; combinational.
- tick, out, NUM_CH, registered single-cycle strobe once per period.
- wave, out, NUM_CH, registered level; toggles on every tick.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst=0: cnt[i]=0, tick=0, wave=0, div[i]=DEF_DIV slice i.
  - This takes effect immediately, without a clk edge.
- Per-channel state: div[i] (CNT_W), cnt[i] (CNT_W), registered tick[i] and wave[i].
- Per-channel update on each rising clk edge, highest priority first:
  1. sync_clr=1: cnt<=0, tick<=0, wave<=0 on all channels. Overrides terminal count.
  2. cfg_we=1 and cfg_ch==i: div[i]<=cfg_div, cnt[i]<=0, tick[i]<=0, wave[i]<=0. The channel restarts its phase.
  3. div[i]==0: channel stalled; cnt<=0, tick<=0, wave holds 0.
  4. en[i]=0: cnt and wave hold, tick<=0. Period is stretched by the number of disabled cycles.
  5. en[i]=1 and cnt[i]==div[i]-1: cnt<=0, tick<=1, wave<=~wave.
  6. en[i]=1 otherwise: cnt<=cnt+1, tick<=0.
- Concurrent sync_clr and cfg_we: both apply. The divisor is written and all phases are cleared.
- cfg_we with cfg_ch>=NUM_CH: ignored. cfg_rdata returns 0 for an out-of-range cfg_ch.
- Period: tick[i] is high for exactly 1 cycle every div[i] enabled cycles. wave period is 2*div[i] enabled cycles, 50% duty.
- div=1: tick stays high continuously while enabled; wave toggles every cycle.
- First tick: after reset release, sync_clr or a write, the first tick appears after the div-th enabled rising edge, i.e. tick is visible in the following cycle.
- Counter arithmetic is unsigned. cnt never exceeds div-1, because every write zeroes cnt. No wrap-around of cnt beyond the terminal count.
- Channels are fully independent; a write to one channel does not disturb the others.
- No combinational path from inputs to tick/wave; cfg_rdata is the only combinational output.

Test Plan:
(Bench overrides NUM_CH=4, CNT_W=8, DEF_DIV = ch0 5, ch1 3, ch2 2, ch3 0.)
1. Hold rst=0 for 5 cycles, then release with en=4'b1111.
   - tick[0] pulses at cycles 5, 10, 15; tick[1] at 3, 6, 9; tick[2] at 2, 4, 6; tick[3] never pulses.
   - wave[0] toggles with each tick[0]; wave[3] stays 0.
2. At cycle 2 of a ch0 period, write cfg_ch=0, cfg_div=7.
   - Next tick[0] is exactly 7 cycles after the write edge, then every 7 cycles.
   - Reading cfg_ch=0 returns cfg_rdata=7.
   - ch1 and ch2 timing is unchanged.
3. Deassert en[1] for 4 cycles mid-period.
   - That tick[1] period becomes 7 cycles; wave[1] holds during the gap.
   - The following period returns to 3.
4. Assert sync_clr on the same edge ch2 reaches its terminal count.
   - No tick[2] that cycle; all wave=0.
   - Next tick[2] 2 cycles later; next tick[0] 5 cycles later.
5. Write div=1 to ch3, then div=0 to ch3.
   - With div=1: tick[3] held high every cycle and wave[3] toggles each cycle.
   - After div=0: tick[3]=0 and wave[3]=0 from the next cycle.
   - Write cfg_ch=3 with an out-of-range value check: in a 5-channel build, cfg_ch=7 is ignored.
6. Drive rst low mid-count between clk edges.
   - tick/wave go to 0 immediately.
   - After release, divisors revert to 5/3/2/0 and Scenario 1 timing repeats.
